pwm_capture8: RTL and testbench
===============================

PWM_CAPTURE8 -- requirements
Module: pwm_capture8

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 8, meaning log2 of PWM frame length in clk cycles (frame = 2^FRAME_W).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning a synchronous, active-high reset.
REQ-004 The block SHALL have port pwm_i, input, 1 bit, meaning the PWM waveform to decode (period 2^FRAME_W cycles, high-first).
REQ-005 The block SHALL have port duty_o, output, FRAME_W bits, meaning the last measured duty cycle (count of high cycles per frame).
REQ-006 The block SHALL have port valid_o, output, 1 bit, meaning a one-cycle strobe when duty_o updates.
REQ-007 The block SHALL have port err_o, output, 1 bit, meaning a one-cycle strobe on a framing error.
REQ-008 The block SHALL have port locked_o, output, 1 bit, meaning the block is in state MEASURE.

Function
REQ-009 The block SHALL define "sample" as pwm_i after the optional synchronizer (REQ-020); "rise" as sample=1 with previous sample=0.
REQ-010 The FSM SHALL have two states, SEARCH and MEASURE, with SEARCH entered on reset.
REQ-011 In SEARCH, a rise SHALL go to MEASURE, zero a position counter and load the high counter with 1.
REQ-012 In SEARCH, 2^FRAME_W consecutive cycles without a rise SHALL strobe valid_o and load duty_o with 0 if sample=0 (constant low), else max value with err_o strobed (constant high); the timeout counter then restarts.
REQ-013 In MEASURE, each cycle SHALL increment the position counter (wrap at 2^FRAME_W) and add sample to a FRAME_W+1-bit high counter.
REQ-014 When the position wraps to 0 (2^FRAME_W cycles after the frame's rise), duty_o SHALL load min(high count, 2^FRAME_W-1) with valid_o high for exactly that cycle.
REQ-015 At wrap, the next frame SHALL start: a rise on that cycle is the normal case; no rise SHALL fall back to SEARCH (also strobing err_o) unless sample=0 and the previous frame measured 0, which stays locked.
REQ-016 A rise at any non-zero position SHALL strobe err_o, discard the partial count without a valid_o, and restart the frame from that rise (stay in MEASURE).
REQ-017 Latency: valid_o SHALL assert exactly 2^FRAME_W cycles after the sampled rise that opened the frame.
REQ-018 duty_o SHALL hold its value between valid_o strobes; valid_o and err_o are never both high except per REQ-012.

Reset
REQ-019 While rst=1, at the next clk edge: duty_o=0, valid_o=0, err_o=0, locked_o=0, all counters zero, previous-sample register 0, synchronizer flops 0, state SEARCH; a reset mid-frame SHALL discard the frame without a strobe.

Configuration
REQ-020 With PWM_CAPTURE_SYNC_EN defined, pwm_i SHALL pass through a 2-flop synchronizer (adds 2 cycles to absolute latency); without it, pwm_i SHALL be sampled by a single register only.

Structure
REQ-021 A shared package SHALL hold the FSM state typedef (SEARCH, MEASURE) and the default FRAME_W constant.
REQ-022 The synchronizer plus edge detector SHALL be a sub-module, pwm_edge_sync, with outputs sample and rise.

Verification
REQ-023 Drive pwm8-style waveform with duty 100 for 4 frames -> locked_o=1 after first rise, valid_o every 256 cycles, duty_o=100, err_o never high.
REQ-024 Duty 255 then duty 1 (same phase) -> duty_o reads 255, then 1 on the following frame, no err_o.
REQ-025 pwm_i held 0 for 600 cycles from reset -> valid_o with duty_o=0 at cycles 256 and 512 after reset release, locked_o=0, no err_o.
REQ-026 pwm_i held 1 for 300 cycles -> valid_o and err_o together at cycle 256, duty_o=255.
REQ-027 Duty 50 frame with extra rise injected at position 120 -> err_o strobe at that rise, no valid_o for the broken frame, next valid_o 256 cycles after the injected rise.
REQ-028 rst asserted at position 200 of a duty-80 frame -> all outputs 0 next cycle, no valid_o; after release, relocks on next rise and reports 80.

Source files
------------

// File: rtl/pwm_capture8_pkg.sv
// Shared definitions for the pwm_capture8 PWM duty-cycle decoder.
// Holds the FSM state type and the default frame width.
package pwm_capture8_pkg;

  localparam int FRAME_W_DEF = 8;

  typedef enum logic {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_capture8_edge_sync.sv
// pwm_edge_sync: registers the PWM input (optionally through a 2-flop synchronizer
// when PWM_CAPTURE_SYNC_EN is defined) and flags rising edges of the sampled signal.
module pwm_edge_sync
  import pwm_capture8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pwm,
  output logic sample,
  output logic rise
);

  logic pwm_p1;
  logic prev_p2;

`ifdef PWM_CAPTURE_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // Stage 0/1: metastability guard for an asynchronous PWM source
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pwm;
      sync_p1 <= sync_p0;
    end
  end

  assign pwm_p1 = sync_p1;
`else
  assign pwm_p1 = pwm;
`endif

  // Stage 2: sample register and its one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sample  <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sample  <= pwm_p1;
      prev_p2 <= sample;
    end
  end

  assign rise = sample & ~prev_p2;

endmodule

// File: rtl/pwm_capture8.sv
// pwm_capture8: locks onto a high-first PWM waveform with a 2^FRAME_W cycle frame and
// reports the high-cycle count per frame. Macro PWM_CAPTURE_SYNC_EN adds an input synchronizer.
module pwm_capture8
  import pwm_capture8_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_i,
  output logic [FRAME_W-1:0] duty_o,
  output logic               valid_o,
  output logic               err_o,
  output logic               locked_o
);

  localparam logic [FRAME_W-1:0] POS_ONE  = 1;
  localparam logic [FRAME_W-1:0] POS_LAST = {FRAME_W{1'b1}};
  localparam logic [FRAME_W:0]   HIGH_ONE = 1;

  function automatic logic [FRAME_W-1:0] sat_duty(input logic [FRAME_W:0] cnt);
    return cnt[FRAME_W] ? {FRAME_W{1'b1}} : cnt[FRAME_W-1:0];
  endfunction

  logic               sample;
  logic               rise;
  state_t             state;
  logic [FRAME_W-1:0] pos;
  logic [FRAME_W:0]   high;
  logic [FRAME_W-1:0] tmo;
  logic               err_pend;
  logic [FRAME_W:0]   sample_ext;

  assign sample_ext = {{FRAME_W{1'b0}}, sample};

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm    (pwm_i),
    .sample (sample),
    .rise   (rise)
  );

  // Frame FSM: sample/rise are already registered, so strobes land one edge after the decision input
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      pos      <= '0;
      high     <= '0;
      tmo      <= '0;
      err_pend <= 1'b0;
      duty_o   <= '0;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      valid_o  <= 1'b0;
      err_o    <= err_pend;
      err_pend <= 1'b0;
      case (state)
        SEARCH: begin
          if (rise) begin
            state    <= MEASURE;
            locked_o <= 1'b1;
            pos      <= '0;
            high     <= HIGH_ONE;
            tmo      <= '0;
          end else if (tmo == POS_LAST) begin
            tmo     <= '0;
            valid_o <= 1'b1;
            duty_o  <= sample ? {FRAME_W{1'b1}} : '0;
            err_o   <= sample;
          end else begin
            tmo <= tmo + POS_ONE;
          end
        end
        MEASURE: begin
          if (pos == POS_LAST) begin
            valid_o <= 1'b1;
            duty_o  <= sat_duty(high);
            pos     <= '0;
            high    <= sample_ext;
            // Losing the frame edge is flagged one cycle later so it never overlaps the duty strobe
            if (!rise && !(!sample && high == '0)) begin
              state    <= SEARCH;
              locked_o <= 1'b0;
              err_pend <= 1'b1;
              tmo      <= '0;
            end
          end else if (rise) begin
            err_o <= 1'b1;
            pos   <= '0;
            high  <= HIGH_ONE;
          end else begin
            pos  <= pos + POS_ONE;
            high <= high + sample_ext;
          end
        end
        default: begin
          state    <= SEARCH;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture8.sv
// Scoreboard bench for pwm_capture8: a frame-level reference model turns each driven
// waveform into expected strobe events and lock status; a monitor compares every cycle.
module tb_pwm_capture8;

  localparam int FW = 8;
  localparam int FL = 1 << FW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_i = 1'b0;
  logic [FW-1:0] duty_o;
  logic          valid_o;
  logic          err_o;
  logic          locked_o;

  pwm_capture8 #(.FRAME_W(FW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pwm_i    (pwm_i),
    .duty_o   (duty_o),
    .valid_o  (valid_o),
    .err_o    (err_o),
    .locked_o (locked_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit valid;
    bit err;
    int duty;
  } ev_t;

  ev_t ev_q[$];
  bit  lk_q[$];
  bit  wave[$];
  int  checks = 0;
  int  errors = 0;
  int  tick = 0;
  int  exp_duty = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at tick %0d", name, act, exp, tick);
    end
  endtask

  // Waveform as seen by the decoder: the value it evaluates at edge e is the input driven before edge e-1
  function automatic bit smp(input int e);
    if (e <= 0) return 1'b0;
    return wave[e-1];
  endfunction

  function automatic bit rse(input int e);
    return smp(e) && !smp(e-1);
  endfunction

  function automatic void push_ev(input int cyc, input bit v, input bit er, input int d);
    ev_t ev;
    ev.cyc = cyc; ev.valid = v; ev.err = er; ev.duty = d;
    ev_q.push_back(ev);
  endfunction

  function automatic void add_frame(input int duty, input int len);
    for (int i = 0; i < len; i++) wave.push_back(i < duty);
  endfunction

  function automatic void add_level(input bit lvl, input int len);
    for (int i = 0; i < len; i++) wave.push_back(lvl);
  endfunction

  // Frame-level reference: walks rises, frames and timeouts over the whole waveform
  task automatic model(input int n, input int base);
    int  e, f, r, w, cnt;
    bit  meas;
    bit  lk[];
    lk = new[n];
    e = 0; f = 0; meas = 1'b0;
    while (e < n) begin
      if (!meas) begin
        r = -1;
        for (int k = e; k < e + FL && k < n; k++) if (r < 0 && rse(k)) r = k;
        if (r >= 0) begin
          meas = 1'b1; f = r; e = r;
        end else if (e + FL - 1 < n) begin
          push_ev(base + e + FL - 1, 1'b1, smp(e + FL - 1), smp(e + FL - 1) ? FL - 1 : 0);
          e = e + FL;
        end else begin
          e = n;
        end
      end else begin
        r = -1;
        for (int k = f + 1; k < f + FL && k < n; k++) if (r < 0 && rse(k)) r = k;
        if (r >= 0) begin
          for (int k = f; k < r; k++) lk[k] = 1'b1;
          push_ev(base + r, 1'b0, 1'b1, 0);
          f = r;
        end else begin
          w = f + FL;
          for (int k = f; k < w && k < n; k++) lk[k] = 1'b1;
          if (w >= n) begin
            e = n;
          end else begin
            cnt = 0;
            for (int k = f; k < w; k++) cnt += int'(smp(k));
            push_ev(base + w, 1'b1, 1'b0, (cnt > FL - 1) ? FL - 1 : cnt);
            if (rse(w) || (!smp(w) && cnt == 0)) begin
              f = w;
            end else begin
              meas = 1'b0;
              e = w + 1;
              if (w + 1 < n) push_ev(base + w + 1, 1'b0, 1'b1, 0);
            end
          end
        end
      end
    end
    for (int i = 0; i < n; i++) lk_q.push_back(lk[i]);
  endtask

  // Called at a negedge: two reset edges, then the waveform, ending on a negedge
  task automatic run_wave();
    int n;
    n = wave.size();
    rst = 1'b1;
    pwm_i = 1'b0;
    repeat (2) @(negedge clk);
    model(n, tick + 1);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0;
      pwm_i = wave[i];
      @(negedge clk);
    end
    rst = 1'b1;
    pwm_i = 1'b0;
    wave.delete();
  endtask

  initial begin : monitor
    bit  r;
    ev_t ev;
    forever begin
      @(posedge clk);
      r = rst;
      tick++;
      #1;
      if (r) begin
        chk("rst_duty", 32'(duty_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_locked", 32'(locked_o), 0);
        chk("missed_events", ev_q.size(), 0);
        ev_q.delete();
        lk_q.delete();
        exp_duty = 0;
      end else begin
        if (lk_q.size() == 0) chk("locked_queue", 1, 0);
        else chk("locked", 32'(locked_o), 32'(lk_q.pop_front()));
        if (valid_o === 1'b1 || err_o === 1'b1) begin
          if (ev_q.size() == 0) begin
            chk("spurious_strobe", {30'd0, valid_o, err_o}, 0);
          end else begin
            ev = ev_q.pop_front();
            chk("strobe_cycle", tick, ev.cyc);
            chk("valid", 32'(valid_o), 32'(ev.valid));
            chk("err", 32'(err_o), 32'(ev.err));
            if (ev.valid) exp_duty = ev.duty;
          end
        end
        chk("duty", 32'(duty_o), exp_duty);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int run;
    @(negedge clk);

    // Constant low from reset: duty-0 reports every frame, never locks
    add_level(1'b0, 600);
    run_wave();

    // Steady duty 100
    add_level(1'b0, 5);
    for (int i = 0; i < 5; i++) add_frame(100, FL);
    while (wave.size() > 5 + 4 * FL + 50) void'(wave.pop_back());
    run_wave();

    // Duty 255 then 1, same phase
    add_level(1'b0, 3);
    add_frame(255, FL);
    add_frame(1, FL);
    add_frame(255, FL);
    while (wave.size() > 3 + 2 * FL + 10) void'(wave.pop_back());
    run_wave();

    // Locked, then input sticks high: saturated frame, fallback, constant-high timeouts
    add_level(1'b0, 4);
    add_frame(100, FL);
    add_frame(100, FL);
    add_level(1'b1, 700);
    run_wave();

    // Duty 50 with an extra rise at position 120, frames re-phased to it
    add_level(1'b0, 6);
    add_frame(50, FL);
    add_frame(50, 120);
    add_frame(50, FL);
    add_frame(50, FL);
    add_frame(50, FL);
    while (wave.size() > 6 + FL + 120 + 2 * FL + 20) void'(wave.pop_back());
    run_wave();

    // Duty 80 interrupted by reset at position 200, then relock
    add_level(1'b0, 7);
    add_frame(80, FL);
    add_frame(80, FL);
    add_frame(80, 200);
    run_wave();
    add_level(1'b0, 9);
    for (int i = 0; i < 4; i++) add_frame(80, FL);
    while (wave.size() > 9 + 3 * FL + 30) void'(wave.pop_back());
    run_wave();

    // Random duties, including 0 (frame loss) and 255
    add_level(1'b0, 5);
    for (int i = 0; i < 8; i++) add_frame(int'($urandom_range(0, FL - 1)), FL);
    run_wave();

    // Random run-length waveform: stray edges, lost frames, timeouts
    for (int i = 0; wave.size() < 1500; i++) begin
      run = int'($urandom_range(1, 300));
      add_level(i[0], run);
    end
    run_wave();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
